// File: rtl/ex_pipe_ctrl_if.sv
// Control bundle between the EX-stage hazard/stall scheduler and the pipeline.
// master: pipeline side (drives instruction/hazard info, receives controls)
// slave : scheduler side (ex_pipe_ctrl)
interface ex_pipe_ctrl_if #(
  parameter int unsigned LAT_W  = 6,
  parameter int unsigned PERF_W = 32
);
  // pipeline -> scheduler
  logic              ex_valid;
  logic [4:0]        ex_rd;
  logic              ex_mem_read;
  logic              ex_multicycle;
  logic [LAT_W-1:0]  ex_mc_latency;
  logic              id_valid;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic              id_uses_rs1;
  logic              id_uses_rs2;
  logic              branch_taken;
  logic              mem_wait;
  // scheduler -> pipeline
  logic              stall_front;
  logic              id_flush;
  logic              id_ex_bubble;
  logic              id_ex_hold;
  logic              combined_stall;
  logic              ex_mem_hold;
  logic              execute_enable;
  logic              mc_busy;
  logic              mc_done;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output ex_valid, ex_rd, ex_mem_read, ex_multicycle, ex_mc_latency,
           id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           branch_taken, mem_wait,
    input  stall_front, id_flush, id_ex_bubble, id_ex_hold, combined_stall,
           ex_mem_hold, execute_enable, mc_busy, mc_done, stall_cycles
  );

  modport slave (
    input  ex_valid, ex_rd, ex_mem_read, ex_multicycle, ex_mc_latency,
           id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           branch_taken, mem_wait,
    output stall_front, id_flush, id_ex_bubble, id_ex_hold, combined_stall,
           ex_mem_hold, execute_enable, mc_busy, mc_done, stall_cycles
  );
endinterface

// File: rtl/ex_pipe_ctrl.sv
// EX-stage hazard and stall scheduler.
// Each cycle decides run / bubble / hold / flush for the EX stage, sequences
// multi-cycle (mul/div) ops with a latency counter, detects load-use hazards,
// applies taken-branch flushes and freezes the pipe on memory back-pressure.
// Ports: clk, reset (async, active-low), bus (ex_pipe_ctrl_if.slave).
// Controls are combinational from state + inputs; only state, mc_cnt and
// stall_cycles are registered.
module ex_pipe_ctrl #(
  parameter int unsigned LAT_W  = 6,
  parameter int unsigned PERF_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  ex_pipe_ctrl_if.slave bus
);

  typedef enum logic {RUN, MC_BUSY} state_t;

  state_t            state, state_d;
  logic [LAT_W-1:0]  mc_cnt, mc_cnt_d;
  logic [PERF_W-1:0] stall_cnt;
  logic              load_use;

  // Load-use: EX load writes a register the (valid) ID instruction reads.
  always_comb begin
    load_use = bus.ex_valid && bus.ex_mem_read && (bus.ex_rd != 5'd0) && bus.id_valid &&
               ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd)));
  end

  // State register and latency counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= RUN;
      mc_cnt <= '0;
    end else begin
      state  <= state_d;
      mc_cnt <= mc_cnt_d;
    end
  end

  // Next state and per-cycle controls, highest-priority condition first.
  always_comb begin
    state_d            = state;
    mc_cnt_d           = mc_cnt;
    bus.stall_front    = 1'b0;
    bus.id_flush       = 1'b0;
    bus.id_ex_bubble   = 1'b0;
    bus.id_ex_hold     = 1'b0;
    bus.combined_stall = 1'b0;
    bus.ex_mem_hold    = 1'b0;
    bus.execute_enable = 1'b0;
    bus.mc_busy        = 1'b0;
    bus.mc_done        = 1'b0;

    if (!reset) begin
      // inputs masked while in reset
    end else if (bus.mem_wait) begin
      // Whole pipe freezes; state and counter hold.
      bus.stall_front = 1'b1;
      bus.id_ex_hold  = 1'b1;
      bus.ex_mem_hold = 1'b1;
    end else if (state == MC_BUSY) begin
      bus.mc_busy = 1'b1;
      if (mc_cnt != '0) begin
        bus.stall_front    = 1'b1;
        bus.id_ex_hold     = 1'b1;
        bus.combined_stall = 1'b1;
        mc_cnt_d           = mc_cnt - LAT_W'(1);
      end else begin
        bus.mc_done        = 1'b1;
        bus.execute_enable = 1'b1;
        state_d            = RUN;
      end
    end else if (bus.ex_valid && bus.ex_multicycle && (bus.ex_mc_latency >= LAT_W'(2))) begin
      // Start cycle plus (latency-2) busy cycles plus the completion cycle.
      bus.stall_front    = 1'b1;
      bus.id_ex_hold     = 1'b1;
      bus.combined_stall = 1'b1;
      mc_cnt_d           = bus.ex_mc_latency - LAT_W'(2);
      state_d            = MC_BUSY;
    end else if (bus.ex_valid && bus.branch_taken) begin
      // ID holds a wrong-path instruction, so load-use is irrelevant here.
      bus.id_flush       = 1'b1;
      bus.id_ex_bubble   = 1'b1;
      bus.execute_enable = 1'b1;
    end else if (load_use) begin
      bus.stall_front    = 1'b1;
      bus.id_ex_bubble   = 1'b1;
      bus.execute_enable = 1'b1;
    end else begin
      bus.execute_enable = bus.ex_valid;
    end
  end

  // Stall-cycle performance counter, wraps freely.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (bus.stall_front) begin
      stall_cnt <= stall_cnt + PERF_W'(1);
    end
  end

  assign bus.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_ex_pipe_ctrl.sv
// Bench for ex_pipe_ctrl: vector table, hand-written multi-cycle sequences and
// randomized stimulus against a cycle-occupancy reference model. A second
// instance with a 4-bit performance counter shares the stimulus.
module tb_ex_pipe_ctrl;
  localparam int unsigned LAT_W   = 6;
  localparam int unsigned PERF_W  = 32;
  localparam int unsigned SMALL_W = 4;

  // Output vector bit order:
  // [8]stall_front [7]id_flush [6]id_ex_bubble [5]id_ex_hold [4]combined_stall
  // [3]ex_mem_hold [2]execute_enable [1]mc_busy [0]mc_done
  localparam logic [8:0] O_NONE  = 9'b000000000;
  localparam logic [8:0] O_EXE   = 9'b000000100;
  localparam logic [8:0] O_LU    = 9'b101000100;
  localparam logic [8:0] O_BR    = 9'b011000100;
  localparam logic [8:0] O_FRZ   = 9'b100101000;
  localparam logic [8:0] O_START = 9'b100110000;
  localparam logic [8:0] O_BUSY  = 9'b100110010;
  localparam logic [8:0] O_DONE  = 9'b000000111;

  typedef struct packed {
    logic             ev;
    logic [4:0]       rd;
    logic             mr;
    logic             mc;
    logic [LAT_W-1:0] lat;
    logic             iv;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             u1;
    logic             u2;
    logic             bt;
    logic             mw;
  } stim_t;

  typedef struct {
    string      name;
    stim_t      s;
    logic [8:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ex_pipe_ctrl_if #(.LAT_W(LAT_W), .PERF_W(PERF_W))  bus ();
  ex_pipe_ctrl_if #(.LAT_W(LAT_W), .PERF_W(SMALL_W)) bus4 ();

  ex_pipe_ctrl #(.LAT_W(LAT_W), .PERF_W(PERF_W))  dut  (.clk(clk), .reset(reset), .bus(bus));
  ex_pipe_ctrl #(.LAT_W(LAT_W), .PERF_W(SMALL_W)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  assign bus4.ex_valid      = bus.ex_valid;
  assign bus4.ex_rd         = bus.ex_rd;
  assign bus4.ex_mem_read   = bus.ex_mem_read;
  assign bus4.ex_multicycle = bus.ex_multicycle;
  assign bus4.ex_mc_latency = bus.ex_mc_latency;
  assign bus4.id_valid      = bus.id_valid;
  assign bus4.id_rs1        = bus.id_rs1;
  assign bus4.id_rs2        = bus.id_rs2;
  assign bus4.id_uses_rs1   = bus.id_uses_rs1;
  assign bus4.id_uses_rs2   = bus.id_uses_rs2;
  assign bus4.branch_taken  = bus.branch_taken;
  assign bus4.mem_wait      = bus.mem_wait;

  int n_tests = 0;
  int n_fail  = 0;

  stim_t cur;

  // ---------------- reference model ----------------
  // m_left: EX-occupancy cycles still owed after the current one (0 = free).
  int          m_left;
  logic [31:0] m_stalls;
  logic [8:0]  m_exp;

  function automatic logic hazard(input stim_t s);
    return s.ev && s.mr && (s.rd != 5'd0) && s.iv &&
           ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
  endfunction

  function automatic logic [8:0] model_out(input stim_t s, input int left, input logic rst_n);
    if (!rst_n)                                      return O_NONE;
    if (s.mw)                                        return O_FRZ;
    if (left > 1)                                    return O_BUSY;
    if (left == 1)                                   return O_DONE;
    if (s.ev && s.mc && int'(s.lat) >= 2)            return O_START;
    if (s.ev && s.bt)                                return O_BR;
    if (hazard(s))                                   return O_LU;
    return s.ev ? O_EXE : O_NONE;
  endfunction

  assign m_exp = model_out(cur, m_left, reset);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left   <= 0;
      m_stalls <= 32'd0;
    end else begin
      if (m_exp[8]) m_stalls <= m_stalls + 32'd1;
      if (!cur.mw) begin
        if (m_left > 0)                                   m_left <= m_left - 1;
        else if (cur.ev && cur.mc && int'(cur.lat) >= 2)  m_left <= int'(cur.lat) - 1;
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic stim_t mk(input logic ev, input logic [4:0] rd, input logic mr,
                               input logic mc, input logic [LAT_W-1:0] lat, input logic iv,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                               input logic u2, input logic bt, input logic mw);
    stim_t s;
    s.ev = ev; s.rd = rd; s.mr = mr; s.mc = mc; s.lat = lat; s.iv = iv;
    s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2; s.bt = bt; s.mw = mw;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    cur                = s;
    bus.ex_valid       = s.ev;
    bus.ex_rd          = s.rd;
    bus.ex_mem_read    = s.mr;
    bus.ex_multicycle  = s.mc;
    bus.ex_mc_latency  = s.lat;
    bus.id_valid       = s.iv;
    bus.id_rs1         = s.rs1;
    bus.id_rs2         = s.rs2;
    bus.id_uses_rs1    = s.u1;
    bus.id_uses_rs2    = s.u2;
    bus.branch_taken   = s.bt;
    bus.mem_wait       = s.mw;
  endtask

  // Drive at the falling edge, sample 2 time units later (well before rising edge).
  task automatic cyc(input stim_t s);
    @(negedge clk);
    apply(s);
    #2;
  endtask

  function automatic logic [8:0] dut_out();
    return {bus.stall_front, bus.id_flush, bus.id_ex_bubble, bus.id_ex_hold,
            bus.combined_stall, bus.ex_mem_hold, bus.execute_enable, bus.mc_busy, bus.mc_done};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    apply(stim_t'(0));
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- test ----------------
  vec_t  tbl[13];
  stim_t idle, lu_s, s;
  int    exp_st;

  initial begin
    idle = stim_t'(0);
    lu_s = mk(1'b1, 5'd5, 1'b1, 1'b0, 6'd0, 1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);

    tbl[0]  = '{"idle",          idle, O_NONE};
    tbl[1]  = '{"ex_valid",      mk(1'b1, 5'd3, 1'b0, 1'b0, 6'd0, 1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0), O_EXE};
    tbl[2]  = '{"lu_rs2",        lu_s, O_LU};
    tbl[3]  = '{"lu_rd0",        mk(1'b1, 5'd0, 1'b1, 1'b0, 6'd0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0), O_EXE};
    tbl[4]  = '{"lu_rs1_unused", mk(1'b1, 5'd7, 1'b1, 1'b0, 6'd0, 1'b1, 5'd7, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0), O_EXE};
    tbl[5]  = '{"lu_rs1",        mk(1'b1, 5'd7, 1'b1, 1'b0, 6'd0, 1'b1, 5'd7, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0), O_LU};
    tbl[6]  = '{"lu_id_invalid", mk(1'b1, 5'd5, 1'b1, 1'b0, 6'd0, 1'b0, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0), O_EXE};
    tbl[7]  = '{"branch_lu",     mk(1'b1, 5'd5, 1'b1, 1'b0, 6'd0, 1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0), O_BR};
    tbl[8]  = '{"branch_no_ex",  mk(1'b0, 5'd5, 1'b1, 1'b0, 6'd0, 1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0), O_NONE};
    tbl[9]  = '{"memwait_lu",    mk(1'b1, 5'd5, 1'b1, 1'b0, 6'd0, 1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1), O_FRZ};
    tbl[10] = '{"mc_lat1",       mk(1'b1, 5'd2, 1'b0, 1'b1, 6'd1, 1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0), O_EXE};
    tbl[11] = '{"mc_lat0",       mk(1'b1, 5'd2, 1'b0, 1'b1, 6'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), O_EXE};
    tbl[12] = '{"mc_no_valid",   mk(1'b0, 5'd2, 1'b0, 1'b1, 6'd4, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), O_NONE};

    reset = 1'b0;
    apply(lu_s);
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", 32'(dut_out()), 32'(O_NONE));
    chk("reset_stalls", bus.stall_cycles, 32'd0);
    apply(idle);
    reset = 1'b1;

    // Table vectors, all issued from RUN.
    exp_st = 0;
    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].s);
      chk(tbl[i].name, 32'(dut_out()), 32'(tbl[i].exp));
      if (tbl[i].exp[8]) exp_st++;
    end
    cyc(idle);
    chk("table_stall_cycles", bus.stall_cycles, 32'(exp_st));

    // Multi-cycle, latency 4.
    do_reset();
    s = mk(1'b1, 5'd9, 1'b0, 1'b1, 6'd4, 1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(s);    chk("mc4_c1", 32'(dut_out()), 32'(O_START));
    cyc(s);    chk("mc4_c2", 32'(dut_out()), 32'(O_BUSY));
    cyc(s);    chk("mc4_c3", 32'(dut_out()), 32'(O_BUSY));
    cyc(s);    chk("mc4_c4", 32'(dut_out()), 32'(O_DONE));
    cyc(idle); chk("mc4_after", 32'(dut_out()), 32'(O_NONE));
    chk("mc4_stalls", bus.stall_cycles, 32'd3);

    // Latency 1 is single-cycle.
    do_reset();
    s = mk(1'b1, 5'd9, 1'b0, 1'b1, 6'd1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(s);    chk("mc1_out", 32'(dut_out()), 32'(O_EXE));
    cyc(idle); chk("mc1_stalls", bus.stall_cycles, 32'd0);

    // Latency 3 with a 2-cycle freeze while the counter sits at 1.
    do_reset();
    s = mk(1'b1, 5'd9, 1'b0, 1'b1, 6'd3, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(s);    chk("frz_start", 32'(dut_out()), 32'(O_START));
    s = idle; s.mw = 1'b1;
    cyc(s);    chk("frz_w1", 32'(dut_out()), 32'(O_FRZ));
    cyc(s);    chk("frz_w2", 32'(dut_out()), 32'(O_FRZ));
    cyc(idle); chk("frz_busy", 32'(dut_out()), 32'(O_BUSY));
    cyc(idle); chk("frz_done", 32'(dut_out()), 32'(O_DONE));
    cyc(idle); chk("frz_after", 32'(dut_out()), 32'(O_NONE));
    chk("frz_stalls", bus.stall_cycles, 32'd4);

    // Reset while busy with mc_cnt=10: op abandoned, no mc_done afterwards.
    do_reset();
    s = mk(1'b1, 5'd9, 1'b0, 1'b1, 6'd12, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(s);    chk("rst_start", 32'(dut_out()), 32'(O_START));
    cyc(idle); chk("rst_busy", 32'(dut_out()), 32'(O_BUSY));
    apply(tbl[1].s);
    reset = 1'b0;
    #1;
    chk("rst_async_out", 32'(dut_out()), 32'(O_NONE));
    chk("rst_async_cnt", bus.stall_cycles, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc(tbl[1].s); chk("rst_run_exe", 32'(dut_out()), 32'(O_EXE));
    for (int i = 0; i < 12; i++) begin
      cyc(idle);
      chk("rst_no_done", 32'(dut_out()), 32'(O_NONE));
    end

    // 16 stalls wrap the 4-bit counter to 0.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cyc(lu_s);
      chk("wrap_lu", 32'(dut_out()), 32'(O_LU));
    end
    cyc(idle);
    chk("wrap_small", 32'(bus4.stall_cycles), 32'd0);
    chk("wrap_big", bus.stall_cycles, 32'd16);

    // Randomized legal stimulus against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      s.ev  = ($urandom_range(0, 3) != 0);
      s.rd  = 5'($urandom_range(0, 3));
      s.iv  = ($urandom_range(0, 3) != 0);
      s.rs1 = 5'($urandom_range(0, 3));
      s.rs2 = 5'($urandom_range(0, 3));
      s.u1  = 1'($urandom_range(0, 1));
      s.u2  = 1'($urandom_range(0, 1));
      s.mc  = ($urandom_range(0, 7) == 0);
      s.lat = LAT_W'($urandom_range(0, 7));
      s.mr  = !s.mc && ($urandom_range(0, 1) == 1);
      s.bt  = !s.mc && ($urandom_range(0, 5) == 0);
      s.mw  = ($urandom_range(0, 7) == 0);
      cyc(s);
      chk("rand_out", 32'(dut_out()), 32'(m_exp));
      chk("rand_stalls", bus.stall_cycles, m_stalls);
      chk("rand_stalls4", 32'(bus4.stall_cycles), 32'(m_stalls[SMALL_W-1:0]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_pipe_ctrl.md
Name: ex_pipe_ctrl

Overview:
- Central hazard and stall scheduler for the EX stage.
- Decides each cycle whether the execute stage runs, bubbles, holds or flushes. Drives combined_stall and execute_enable into the EX stage, and hold/flush controls into the IF/ID and ID/EX registers.
- Sequences multi-cycle EX operations (mul/div class) with a latency counter. Detects load-use hazards, applies branch flushes and honours memory back-pressure.

Parameters:
- LAT_W, 6, width of the multi-cycle latency field.
- PERF_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- ex_valid  input  1  valid instruction in ID/EX (decode_enable_out)
- ex_rd  input  5  destination register of the EX instruction
- ex_mem_read  input  1  EX instruction is a load
- ex_multicycle  input  1  EX instruction needs the multi-cycle path
- ex_mc_latency  input  LAT_W  total EX occupancy in cycles for a multi-cycle op
- id_valid  input  1  valid instruction in IF/ID
- id_rs1, id_rs2  input  5 each  source registers of the ID instruction
- id_uses_rs1, id_uses_rs2  input  1 each  source-register-read flags
- branch_taken  input  1  EX resolved a taken branch or jump
- mem_wait  input  1  MEM stage not ready; whole pipe must freeze
- stall_front  output  1  hold PC and IF/ID
- id_flush  output  1  load NOP into IF/ID
- id_ex_bubble  output  1  load NOP into ID/EX
- id_ex_hold  output  1  hold ID/EX contents
- combined_stall  output  1  EX stage inserts bubble into EX/MEM
- ex_mem_hold  output  1  hold EX/MEM contents
- execute_enable  output  1  EX stage captures its result this cycle
- mc_busy  output  1  FSM in MC_BUSY
- mc_done  output  1  final cycle of a multi-cycle op
- stall_cycles  output  PERF_W  count of cycles with stall_front=1

Behaviour:
- Reset (reset=0, asynchronous):
  - state=RUN, mc_cnt=0, stall_cycles=0.
  - All control outputs are 0, computed from state RUN with inputs masked.
- Output timing:
  - All control outputs are combinational from the current state and inputs (zero latency).
  - Only state, mc_cnt and stall_cycles are registered.
- FSM states: RUN and MC_BUSY. mc_cnt is LAT_W bits wide.
- Per-cycle priority, highest first:
  1. mem_wait=1, any state (freeze):
     - stall_front=1, id_ex_hold=1, ex_mem_hold=1.
     - All other controls are 0, including execute_enable.
     - state and mc_cnt hold. branch_taken and load-use are ignored and re-evaluated when mem_wait drops.
  2. MC_BUSY with mc_cnt≠0:
     - stall_front=1, id_ex_hold=1, combined_stall=1, mc_busy=1, execute_enable=0.
     - mc_cnt decrements.
  3. MC_BUSY with mc_cnt=0 (completion):
     - mc_busy=1, mc_done=1, execute_enable=1.
     - All stall outputs are 0. Next state is RUN.
  4. RUN, ex_valid=1, ex_multicycle=1, ex_mc_latency≥2 (start):
     - stall_front=1, id_ex_hold=1, combined_stall=1, execute_enable=0.
     - mc_cnt←ex_mc_latency−2. Next state is MC_BUSY.
     - Total EX occupancy is exactly ex_mc_latency cycles.
     - ex_mc_latency of 0 or 1 is treated as single-cycle (falls through to rule 7).
  5. RUN, ex_valid=1, branch_taken=1:
     - id_flush=1, id_ex_bubble=1, execute_enable=1.
     - Load-use is suppressed because the ID instruction is wrong-path.
  6. RUN, load-use:
     - Condition: ex_valid & ex_mem_read & ex_rd≠0 & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
     - Response: stall_front=1, id_ex_bubble=1, execute_enable=1, for exactly one cycle.
  7. Otherwise: execute_enable=ex_valid; all other controls are 0.
- Input constraints:
  - ex_multicycle and ex_mem_read are mutually exclusive. If both are set, multi-cycle wins.
  - branch_taken with ex_multicycle is illegal. If both are set, multi-cycle wins.
- Output invariants:
  - id_ex_hold and id_ex_bubble are never both 1.
  - combined_stall and ex_mem_hold are never both 1.
- stall_cycles increments by 1 on every clock edge where stall_front=1. It wraps modulo 2^PERF_W with no saturation.
- Reset asserted mid multi-cycle op: immediately returns to RUN with mc_cnt=0. The op is abandoned and no mc_done is produced.

Test Plan:
- Release reset, idle with ex_valid=0 → all controls 0, stall_cycles=0. Then ex_valid=1 → execute_enable=1 the same cycle.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1, id_valid=1 → stall_front=1 and id_ex_bubble=1 for one cycle, stall_cycles=1. Same stimulus with ex_rd=0 → no stall.
- Multi-cycle with ex_mc_latency=4:
  - combined_stall=1 for cycles 1–3; mc_done=1 and execute_enable=1 in cycle 4.
  - stall_cycles=3. ex_mc_latency=1 produces no stall.
- mem_wait=1 for 2 cycles during MC_BUSY with mc_cnt=1 → counter frozen; completion is delayed by exactly 2 cycles; ex_mem_hold=1 and combined_stall=0 while frozen.
- branch_taken=1 together with a load-use match → id_flush=1, id_ex_bubble=1, stall_front=0.
- Drive reset low in MC_BUSY with mc_cnt=10 → outputs 0 asynchronously; after release, state=RUN and no mc_done is seen. Preload stall_cycles near 2^PERF_W−1 (small PERF_W build, e.g. 4) → count wraps to 0.
